// File: rtl/interp_ram_responder.sv
// interp_ram_responder: dual-port word-addressed scratch RAM serving the
// interpolation datapath bus (port 1 read/write, port 2 read-only), with a
// host valid/ready load channel and a never-stalling dump (read-back) channel.
// The block owns turnaround on both bidirectional data buses.
//
// Build option: define RAM_WR_FORWARD_EN to make a port-2 read that samples
// the same edge as a port-1 write to the same word return the new data
// (write-through). Left undefined, that read returns the old data.
module interp_ram_responder #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DEPTH_LOG2    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] ram_add1,
  input  logic [ADDRESS_WIDTH-1:0] ram_add2,
  input  logic                     mem_write,
  inout  wire  [WORD_SIZE-1:0]     ram_data1,
  inout  wire  [WORD_SIZE-1:0]     ram_data2,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [WORD_SIZE-1:0]     load_data,
  input  logic                     load_last,
  input  logic                     dump_req,
  input  logic [ADDRESS_WIDTH-1:0] dump_addr,
  output logic                     dump_valid,
  output logic [WORD_SIZE-1:0]     dump_data,
  output logic                     serving,
  output logic                     addr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Word storage; deliberately not reset so contents survive reset and
  // state changes.
  logic [WORD_SIZE-1:0] mem [0:DEPTH-1];

  // Registered read data for the two datapath ports.
  logic [WORD_SIZE-1:0] rd1_p1;
  logic [WORD_SIZE-1:0] rd2_p1;
  // Port-1 read data is only presented after an edge that saw a read in SERVE,
  // which gives the one-cycle turnaround after mem_write falls.
  logic                 vld1_p1;

  logic ld_fire;
  logic wr1;
  logic fwd_hit;
  logic err_now;
  logic drv1;
  logic drv2;

  // Word index inside the RAM: addresses wrap modulo the depth.
  function automatic logic [DEPTH_LOG2-1:0] idx(input logic [ADDRESS_WIDTH-1:0] a);
    return a[DEPTH_LOG2-1:0];
  endfunction

  // True when the address has any bit set above the RAM index range.
  function automatic logic hi_set(input logic [ADDRESS_WIDTH-1:0] a);
    return |a[ADDRESS_WIDTH-1:DEPTH_LOG2];
  endfunction

  assign ld_fire = (state_q == LOAD) && load_valid;
  assign wr1     = (state_q == SERVE) && mem_write;

`ifdef RAM_WR_FORWARD_EN
  assign fwd_hit = wr1 && (idx(ram_add1) == idx(ram_add2));
`else
  assign fwd_hit = 1'b0;
`endif

  // Any address actually used this cycle with out-of-range upper bits.
  assign err_now = (ld_fire && hi_set(load_addr))
                || ((state_q == SERVE) && (hi_set(ram_add1) || hi_set(ram_add2)))
                || (dump_req && hi_set(dump_addr));

  // Bus drivers: port 1 releases combinationally when mem_write rises; both
  // buses are released whenever the block is not serving (including reset).
  assign drv1 = (state_q == SERVE) && vld1_p1 && !mem_write;
  assign drv2 = (state_q == SERVE);

  assign ram_data1 = drv1 ? rd1_p1 : {WORD_SIZE{1'bz}};
  assign ram_data2 = drv2 ? rd2_p1 : {WORD_SIZE{1'bz}};

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    serving    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) state_d = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid && load_last) state_d = SERVE;
      end
      SERVE: begin
        serving = 1'b1;
        if (load_valid) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, port-1 read valid, dump channel, sticky address error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      vld1_p1    <= 1'b0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      addr_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      vld1_p1    <= (state_d == SERVE) && !mem_write;
      dump_valid <= dump_req;
      if (dump_req) dump_data <= mem[idx(dump_addr)];
      if (err_now) addr_err <= 1'b1;
    end
  end

  // Memory writes (port 1 in SERVE, host load in LOAD) and synchronous port reads.
  always_ff @(posedge clk) begin
    if (wr1) begin
      mem[idx(ram_add1)] <= ram_data1;
    end else if (ld_fire) begin
      mem[idx(load_addr)] <= load_data;
    end
    rd1_p1 <= mem[idx(ram_add1)];
    if (fwd_hit) begin
      rd2_p1 <= ram_data1;
    end else begin
      rd2_p1 <= mem[idx(ram_add2)];
    end
  end

endmodule

// File: doc/interp_ram_responder.md
# interp_ram_responder

Dual-port word-addressed scratch RAM that answers the interpolation datapath's memory bus (`ram_add1`/`ram_data1` read-write, `ram_add2`/`ram_data2` read-only, `mem_write`). A host preloads it through a valid/ready load channel with t0, t1, m and the u vectors, and can read results back through a dump channel. The block owns bus turnaround on both bidirectional data buses so the datapath never contends with it.

## Interface
- `WORD_SIZE`, 16, data word width
- `ADDRESS_WIDTH`, 16, bus address width
- `DEPTH_LOG2`, 8, log2 of RAM words (256)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ram_add1`  in  ADDRESS_WIDTH  port-1 address from datapath
- `ram_add2`  in  ADDRESS_WIDTH  port-2 address from datapath
- `mem_write`  in  1  port-1 write strobe from datapath
- `ram_data1`  inout  WORD_SIZE  port-1 data; driven by block on reads, by datapath on writes
- `ram_data2`  inout  WORD_SIZE  port-2 read data; driven by block only
- `load_valid`  in  1  host load word valid
- `load_ready`  out  1  block accepts load word
- `load_addr`  in  ADDRESS_WIDTH  load address
- `load_data`  in  WORD_SIZE  load word
- `load_last`  in  1  final load word
- `dump_req`  in  1  host read-back request
- `dump_addr`  in  ADDRESS_WIDTH  read-back address
- `dump_valid`  out  1  read-back data valid
- `dump_data`  out  WORD_SIZE  read-back data
- `serving`  out  1  block in SERVE state
- `addr_err`  out  1  sticky: any access with address bits above DEPTH_LOG2 set

## Operation
- States: IDLE, LOAD, SERVE. Reset → IDLE.
- IDLE: `load_valid`=1 → LOAD. Buses high-Z.
- LOAD: `load_ready`=1; handshake (valid&ready) writes `load_data` to `load_addr`. Handshake with `load_last`=1 → SERVE. `load_valid`=0 holds LOAD.
- SERVE: `serving`=1. Port 1: `mem_write`=0 → block drives `ram_data1`; `mem_write`=1 → block releases `ram_data1` combinationally and writes the sampled value to `ram_add1` at the edge. Port 2: block always drives `ram_data2`.
- SERVE with `load_valid`=1 → LOAD next cycle; the word is not accepted this cycle (`load_ready`=0).
- Addresses use low DEPTH_LOG2 bits (wrap modulo 256); any nonzero upper bit on a used address sets `addr_err` until reset.
- Dump channel works in every state and never stalls.
- Memory contents not reset; contents survive state changes.

## Timing
- Reset values: `load_ready`=0, `dump_valid`=0, `dump_data`=0, `serving`=0, `addr_err`=0, `ram_data1`/`ram_data2` high-Z, state IDLE.
- Reads are synchronous: address sampled at edge N, data driven during cycle N+1 and held until the next edge.
- Port-1 write: data/address sampled at the edge where `mem_write`=1; visible on either port from read address sampled at the next edge.
- `ram_data1` turnaround: high-Z within the same cycle `mem_write` rises; driven again the cycle after `mem_write` falls.
- Dump: `dump_req` at edge N → `dump_valid`=1, `dump_data` valid cycle N+1 only.
- Simultaneous load write and port-1 write cannot occur (disjoint states). Dump and port reads to the same address both return the same value.
- Reset mid-operation: drop to IDLE immediately, release buses, discard in-flight dump.

## Configuration
- `RAM_WR_FORWARD_EN` defined: port-2 read sampled on the same edge as a port-1 write to the same address returns the new data (write-through).
- Undefined: same case returns the old data (read-before-write).

## Test plan
- Load 0x0005→addr 1, 0x0009→addr 2 (last) → `serving`=1 next cycle; `ram_add1`=1 → `ram_data1`=0x0005 one cycle later.
- SERVE, `mem_write`=1, `ram_add1`=0x0A, datapath drives 0x1234 → `ram_data1` high-Z same cycle; `ram_add2`=0x0A next edge → `ram_data2`=0x1234.
- Same-edge write 0xBEEF and port-2 read of addr 0x0A (old 0x1234) → 0xBEEF with `RAM_WR_FORWARD_EN`, 0x1234 without.
- `ram_add2`=0x0103 → `addr_err`=1 sticky, `ram_data2`=mem[0x03].
- `dump_req`, `dump_addr`=2 in IDLE after load → `dump_valid` pulse one cycle, `dump_data`=0x0009.
- Assert `rst`=0 mid-SERVE read → buses high-Z, `serving`=0 immediately; memory still returns 0x0005 at addr 1 after reload to SERVE.
